// File: rtl/alu_unit.sv
// Integer execute stage: one RV32I ALU/branch/jump op per cycle, registered onto the
// result broadcast with single-cycle latency and no backpressure.
module alu_unit #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 32,
   parameter int ROB_ID_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rdy,
   input  logic                rollback,
   input  logic                in_valid,
   input  logic [6:0]          in_opcode,
   input  logic [2:0]          in_func3,
   input  logic                in_func1,
   input  logic [DATA_W-1:0]   in_data1,
   input  logic [DATA_W-1:0]   in_data2,
   input  logic [DATA_W-1:0]   in_imm,
   input  logic [DATA_W-1:0]   in_off,
   input  logic [ADDR_W-1:0]   in_pc,
   input  logic [ROB_ID_W-1:0] in_rob_id,
   output logic                out_valid,
   output logic [ROB_ID_W-1:0] out_rob_id,
   output logic [DATA_W-1:0]   out_data,
   output logic                out_jump,
   output logic [ADDR_W-1:0]   out_target
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef struct packed {
      logic                valid;
      logic [ROB_ID_W-1:0] rob_id;
      logic [DATA_W-1:0]   data;
      logic                jump;
      logic [ADDR_W-1:0]   target;
   } result_t;

   result_t res_d, res_q;

   logic [DATA_W-1:0] op_b;
   logic [4:0]        shamt;
   logic              alu_sub;
   logic [DATA_W-1:0] alu_res;
   logic              lt_s, lt_u, eq;
   logic              br_taken;
   logic [ADDR_W-1:0] pc_seq, pc_off, jalr_tgt;
   logic [DATA_W-1:0] jalr_sum;

   // Operand select and integer ALU shared by OP and OP-IMM.
   always_comb begin
      op_b    = (in_opcode == OPC_OP) ? in_data2 : in_imm;
      shamt   = op_b[4:0];
      // OP-IMM has no SUBI; funct7[5] only selects SRAI there.
      alu_sub = (in_opcode == OPC_OP) && in_func1;
      lt_s    = $signed(in_data1) < $signed(op_b);
      lt_u    = in_data1 < op_b;
      alu_res = '0;
      case (in_func3)
         3'b000:  alu_res = alu_sub ? (in_data1 - op_b) : (in_data1 + op_b);
         3'b001:  alu_res = in_data1 << shamt;
         3'b010:  alu_res = {{(DATA_W-1){1'b0}}, lt_s};
         3'b011:  alu_res = {{(DATA_W-1){1'b0}}, lt_u};
         3'b100:  alu_res = in_data1 ^ op_b;
         3'b101:  alu_res = in_func1 ? DATA_W'($signed(in_data1) >>> shamt)
                                     : (in_data1 >> shamt);
         3'b110:  alu_res = in_data1 | op_b;
         3'b111:  alu_res = in_data1 & op_b;
         default: alu_res = '0;
      endcase
   end

   // Branch resolution always compares the two register operands.
   always_comb begin
      eq       = in_data1 == in_data2;
      br_taken = 1'b0;
      case (in_func3)
         3'b000:  br_taken = eq;
         3'b001:  br_taken = !eq;
         3'b100:  br_taken = $signed(in_data1) <  $signed(in_data2);
         3'b101:  br_taken = $signed(in_data1) >= $signed(in_data2);
         3'b110:  br_taken = in_data1 <  in_data2;
         3'b111:  br_taken = in_data1 >= in_data2;
         default: br_taken = 1'b0;
      endcase
   end

   always_comb begin
      pc_seq   = in_pc + ADDR_W'(4);
      pc_off   = in_pc + ADDR_W'(in_off);
      jalr_sum = in_data1 + in_imm;
      jalr_tgt = ADDR_W'(jalr_sum) & ~ADDR_W'(1);
   end

   // Next broadcast; unsupported ops still complete so the ROB entry retires.
   always_comb begin
      res_d       = res_q;
      res_d.valid = in_valid;
      if (in_valid) begin
         res_d.rob_id = in_rob_id;
         res_d.data   = '0;
         res_d.jump   = 1'b0;
         res_d.target = pc_seq;
         case (in_opcode)
            OPC_OP, OPC_OP_IMM: res_d.data = alu_res;
            OPC_LUI:            res_d.data = in_imm;
            OPC_AUIPC:          res_d.data = DATA_W'(in_pc) + in_imm;
            OPC_JAL: begin
               res_d.data   = DATA_W'(pc_seq);
               res_d.jump   = 1'b1;
               res_d.target = pc_off;
            end
            OPC_JALR: begin
               res_d.data   = DATA_W'(pc_seq);
               res_d.jump   = 1'b1;
               res_d.target = jalr_tgt;
            end
            OPC_BRANCH: begin
               res_d.jump   = br_taken;
               res_d.target = br_taken ? pc_off : pc_seq;
            end
            default: ;
         endcase
      end
   end

   // Flush wins over stall so a rollback during rdy-low still kills the broadcast.
   always_ff @(posedge clk) begin
      if (rst || rollback) begin
         res_q <= '0;
      end else if (rdy) begin
         res_q <= res_d;
      end
   end

   assign out_valid  = res_q.valid;
   assign out_rob_id = res_q.rob_id;
   assign out_data   = res_q.data;
   assign out_jump   = res_q.jump;
   assign out_target = res_q.target;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed vector table, flush/stall/reset
// sequences, then randomized traffic checked against a behavioural model.
module tb_alu_unit;

   localparam logic [6:0] OP  = 7'b0110011, OPI = 7'b0010011, LUI = 7'b0110111;
   localparam logic [6:0] AUI = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111;
   localparam logic [6:0] BR  = 7'b1100011;

   logic        clk = 1'b0;
   logic        rst, rdy, rollback, in_valid, in_func1;
   logic [6:0]  in_opcode;
   logic [2:0]  in_func3;
   logic [31:0] in_data1, in_data2, in_imm, in_off, in_pc;
   logic [3:0]  in_rob_id;
   logic        out_valid, out_jump;
   logic [3:0]  out_rob_id;
   logic [31:0] out_data, out_target;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   alu_unit #(.DATA_W(32), .ADDR_W(32), .ROB_ID_W(4)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .in_valid(in_valid),
      .in_opcode(in_opcode), .in_func3(in_func3), .in_func1(in_func1),
      .in_data1(in_data1), .in_data2(in_data2), .in_imm(in_imm), .in_off(in_off),
      .in_pc(in_pc), .in_rob_id(in_rob_id), .out_valid(out_valid),
      .out_rob_id(out_rob_id), .out_data(out_data), .out_jump(out_jump),
      .out_target(out_target)
   );

   typedef struct {
      string       name;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic        f1;
      logic [31:0] d1, d2, imm, off, pc;
      logic [31:0] e_data;
      logic        e_jump;
      logic [31:0] e_tgt;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input string n, input logic [6:0] opc, input logic [2:0] f3,
                               input logic f1, input logic [31:0] d1, input logic [31:0] d2,
                               input logic [31:0] imm, input logic [31:0] off,
                               input logic [31:0] pc, input logic [31:0] ed,
                               input logic ej, input logic [31:0] et);
      vec_t v;
      v.name = n; v.opc = opc; v.f3 = f3; v.f1 = f1; v.d1 = d1; v.d2 = d2;
      v.imm = imm; v.off = off; v.pc = pc; v.e_data = ed; v.e_jump = ej; v.e_tgt = et;
      return v;
   endfunction

   // Reference: RV32I semantics written directly from the ISA rules.
   function automatic void model(input vec_t v, output logic [31:0] d, output logic j,
                                 output logic [31:0] t);
      logic [31:0] a, b;
      int          sa;
      a = v.d1;
      b = (v.opc == OP) ? v.d2 : v.imm;
      sa = int'(b % 32);
      d = 32'h0; j = 1'b0; t = v.pc + 32'd4;
      case (v.opc)
         OP, OPI: case (v.f3)
            3'd0: d = (v.opc == OP && v.f1) ? a - b : a + b;
            3'd1: d = a * (32'd1 << sa);
            3'd2: d = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            3'd3: d = (a < b) ? 32'd1 : 32'd0;
            3'd4: d = a ^ b;
            3'd5: d = v.f1 ? 32'(int'(a) >>> sa) : a / (32'd1 << sa);
            3'd6: d = a | b;
            default: d = a & b;
         endcase
         LUI: d = v.imm;
         AUI: d = v.pc + v.imm;
         JAL: begin d = v.pc + 32'd4; j = 1'b1; t = v.pc + v.off; end
         JALR: begin d = v.pc + 32'd4; j = 1'b1; t = (v.d1 + v.imm) & 32'hFFFF_FFFE; end
         BR: begin
            case (v.f3)
               3'd0: j = v.d1 == v.d2;
               3'd1: j = v.d1 != v.d2;
               3'd4: j = int'(v.d1) <  int'(v.d2);
               3'd5: j = int'(v.d1) >= int'(v.d2);
               3'd6: j = v.d1 <  v.d2;
               3'd7: j = v.d1 >= v.d2;
               default: j = 1'b0;
            endcase
            if (j) t = v.pc + v.off;
         end
         default: ;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input vec_t v, input logic [3:0] rob);
      in_opcode = v.opc; in_func3 = v.f3; in_func1 = v.f1; in_data1 = v.d1;
      in_data2 = v.d2; in_imm = v.imm; in_off = v.off; in_pc = v.pc; in_rob_id = rob;
   endtask

   task automatic chk_all(input string n, input logic v, input logic [3:0] rob,
                          input logic [31:0] d, input logic j, input logic [31:0] t);
      chk({n, ".valid"},  {31'd0, out_valid}, {31'd0, v});
      chk({n, ".rob"},    {28'd0, out_rob_id}, {28'd0, rob});
      chk({n, ".data"},   out_data, d);
      chk({n, ".jump"},   {31'd0, out_jump}, {31'd0, j});
      chk({n, ".target"}, out_target, t);
   endtask

   logic [6:0] opcs[9];

   initial begin
      vec_t        v;
      logic        e_valid, e_jump, mj;
      logic [3:0]  e_rob;
      logic [31:0] e_data, e_tgt, md, mt;

      rst = 1'b1; rdy = 1'b1; rollback = 1'b0; in_valid = 1'b0;
      drive(mk("z", 7'h0, 3'd0, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0, 0), 4'd0);
      tick(); tick();
      chk_all("reset", 1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
      rst = 1'b0;

      tbl.push_back(mk("add",   OP,  3'd0, 1'b0, 5, 7, 0, 0, 32'h0, 32'd12, 1'b0, 32'h4));
      tbl.push_back(mk("sub",   OP,  3'd0, 1'b1, 5, 7, 0, 0, 32'h10, 32'hFFFF_FFFE, 1'b0, 32'h14));
      tbl.push_back(mk("srai",  OPI, 3'd5, 1'b1, 32'h8000_0000, 0, 4, 0, 0, 32'hF800_0000, 1'b0, 4));
      tbl.push_back(mk("srli",  OPI, 3'd5, 1'b0, 32'h8000_0000, 0, 4, 0, 0, 32'h0800_0000, 1'b0, 4));
      tbl.push_back(mk("addi_f1", OPI, 3'd0, 1'b1, 10, 0, 3, 0, 0, 32'd13, 1'b0, 4));
      tbl.push_back(mk("sll_amt", OP,  3'd1, 1'b0, 1, 32'h21, 0, 0, 0, 32'd2, 1'b0, 4));
      tbl.push_back(mk("slt",   OP,  3'd2, 1'b0, 32'hFFFF_FFFF, 1, 0, 0, 0, 32'd1, 1'b0, 4));
      tbl.push_back(mk("sltu",  OP,  3'd3, 1'b0, 32'hFFFF_FFFF, 1, 0, 0, 0, 32'd0, 1'b0, 4));
      tbl.push_back(mk("blt",   BR,  3'd4, 1'b0, 32'hFFFF_FFFF, 1, 0, 32'h20, 32'h100, 0, 1'b1, 32'h120));
      tbl.push_back(mk("bltu",  BR,  3'd6, 1'b0, 32'hFFFF_FFFF, 1, 0, 32'h20, 32'h100, 0, 1'b0, 32'h104));
      tbl.push_back(mk("beq",   BR,  3'd0, 1'b0, 9, 9, 0, 32'hFFFF_FFF8, 32'h40, 0, 1'b1, 32'h38));
      tbl.push_back(mk("br_bad", BR, 3'd2, 1'b0, 9, 9, 0, 32'h20, 32'h40, 0, 1'b0, 32'h44));
      tbl.push_back(mk("jalr",  JALR, 3'd0, 1'b0, 32'h1003, 0, 4, 0, 32'h200, 32'h204, 1'b1, 32'h1006));
      tbl.push_back(mk("jal",   JAL, 3'd0, 1'b0, 0, 0, 0, 32'hFFFF_FFF0, 32'h300, 32'h304, 1'b1, 32'h2F0));
      tbl.push_back(mk("lui",   LUI, 3'd0, 1'b0, 0, 0, 32'h1234_5000, 0, 32'h8, 32'h1234_5000, 1'b0, 32'hC));
      tbl.push_back(mk("auipc", AUI, 3'd0, 1'b0, 0, 0, 32'h2000, 0, 32'h1000, 32'h3000, 1'b0, 32'h1004));
      tbl.push_back(mk("bad_opc", 7'h7F, 3'd0, 1'b0, 1, 2, 3, 4, 32'h50, 0, 1'b0, 32'h54));

      // Directed vectors, issued back-to-back.
      in_valid = 1'b1;
      foreach (tbl[i]) begin
         drive(tbl[i], 4'(i + 3));
         tick();
         chk_all(tbl[i].name, 1'b1, 4'(i + 3), tbl[i].e_data, tbl[i].e_jump, tbl[i].e_tgt);
      end
      in_valid = 1'b0;
      tick();
      chk("idle.valid", {31'd0, out_valid}, 32'd0);

      // Stall: result held while rdy is low even with a new op presented.
      in_valid = 1'b1; drive(tbl[0], 4'd3);
      tick();
      rdy = 1'b0; drive(tbl[1], 4'd9);
      tick();
      chk_all("hold1", 1'b1, 4'd3, 32'd12, 1'b0, 32'h4);
      tick();
      chk_all("hold2", 1'b1, 4'd3, 32'd12, 1'b0, 32'h4);
      rdy = 1'b1; in_valid = 1'b0;
      tick();
      chk("post_hold.valid", {31'd0, out_valid}, 32'd0);

      // Rollback discards the op issued in the same cycle and clears outputs.
      in_valid = 1'b1; drive(tbl[13], 4'd5);
      tick();
      chk("pre_rb.jump", {31'd0, out_jump}, 32'd1);
      rollback = 1'b1; drive(tbl[12], 4'd6);
      tick();
      chk_all("rollback", 1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
      rollback = 1'b0; in_valid = 1'b0;

      // Reset mid-stream.
      in_valid = 1'b1; drive(tbl[13], 4'd7);
      tick();
      chk("pre_rst.valid", {31'd0, out_valid}, 32'd1);
      rst = 1'b1;
      tick();
      chk_all("rst_mid", 1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
      rst = 1'b0; in_valid = 1'b0;
      tick();

      // Randomized traffic with stalls, flushes and resets against the model.
      opcs = '{OP, OPI, LUI, AUI, JAL, JALR, BR, 7'h00, 7'h0F};
      e_valid = 1'b0; e_rob = '0; e_data = '0; e_jump = 1'b0; e_tgt = '0;
      for (int c = 0; c < 600; c++) begin
         v = mk("rnd", opcs[$urandom_range(0, 8)], 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, $urandom,
                $urandom, 0, 1'b0, 0);
         if ($urandom_range(0, 3) == 0) v.d2 = v.d1;
         if ($urandom_range(0, 3) == 0) v.imm = $urandom_range(0, 63);
         drive(v, 4'($urandom));
         in_valid = ($urandom_range(0, 3) != 0);
         rdy      = ($urandom_range(0, 9) != 0);
         rollback = ($urandom_range(0, 24) == 0);
         rst      = ($urandom_range(0, 49) == 0);
         if (rst || rollback) begin
            e_valid = 1'b0; e_rob = '0; e_data = '0; e_jump = 1'b0; e_tgt = '0;
         end else if (rdy) begin
            e_valid = in_valid;
            if (in_valid) begin
               model(v, md, mj, mt);
               e_rob = in_rob_id; e_data = md; e_jump = mj; e_tgt = mt;
            end
         end
         tick();
         chk("rnd.valid", {31'd0, out_valid}, {31'd0, e_valid});
         if (e_valid) begin
            chk("rnd.rob",    {28'd0, out_rob_id}, {28'd0, e_rob});
            chk("rnd.data",   out_data, e_data);
            chk("rnd.jump",   {31'd0, out_jump}, {31'd0, e_jump});
            chk("rnd.target", out_target, e_tgt);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
